lsu: RTL and testbench

Load/store unit: the requester side of the CPU's 128-word data memory. It accepts byte/halfword/word load and store requests from the execute stage over a valid/ready handshake, checks alignment and range, and drives the memory's word-wide `memwrite`/`memread` port. Sub-word stores use a read-modify-write sequence because the memory has no byte enables. Load data is returned sign- or zero-extended over a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu.sv | 127 ++++++++++++
 tb/tb_lsu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size encodings,
// controller states, default memory depth and the request fault check.
package lsu_pkg;

    localparam int MEM_WORDS_DEFAULT = 128;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_e;

    // Reserved size, natural-alignment violation, or a byte address past the end of memory.
    function automatic logic is_fault(input logic [1:0] size,
                                      input logic [31:0] addr,
                                      input int unsigned mem_words);
        logic [31:0] limit;
        limit = 32'(mem_words) << 2;
        is_fault = (size == 2'd3)
                || (size == SIZE_H && addr[0])
                || (size == SIZE_W && addr[1:0] != 2'b00)
                || (addr >= limit);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word extraction with sign/zero extension for
// loads, and sub-word merge into the old word for read-modify-write stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ext_data,
    output logic [31:0] merged
);

    logic [4:0]         byte_base;
    logic [4:0]         half_base;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_x;
    logic signed [31:0] half_x;

    always_comb begin
        byte_base = {lane, 3'b000};
        half_base = {lane[1], 4'b0000};
        byte_s    = word[byte_base +: 8];
        half_s    = word[half_base +: 16];
        byte_x    = byte_s;
        half_x    = half_s;
        ext_data  = word;
        merged    = word;
        case (size)
            SIZE_B: begin
                ext_data = is_unsigned ? {24'b0, byte_s} : byte_x;
                merged[byte_base +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                ext_data = is_unsigned ? {16'b0, half_s} : half_x;
                merged[half_base +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts load/store requests, checks them, drives the
// word-wide data memory port (RMW for sub-word stores) and returns a response.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_data_out
);

    lsu_state_e  state;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] ext_data;
    logic [31:0] merged;

    lsu_align u_align (
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .word        (mem_data_out),
        .wdata       (wdata_q),
        .ext_data    (ext_data),
        .merged      (merged)
    );

    // Every output is a flop so nothing combinational reaches the ports.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_fault     <= 1'b0;
            resp_rdata     <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            size_q         <= '0;
            lane_q         <= '0;
            uns_q          <= 1'b0;
            wdata_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        size_q      <= req_size;
                        lane_q      <= req_addr[1:0];
                        uns_q       <= req_unsigned;
                        wdata_q     <= req_wdata;
                        mem_address <= 32'(req_addr[ADDR_W+1:2]);
                        req_ready   <= 1'b0;
                        resp_rdata  <= '0;
                        if (is_fault(req_size, req_addr, MEM_WORDS)) begin
                            resp_fault <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else if (!req_write) begin
                            mem_read <= 1'b1;
                            state    <= ST_LOAD;
                        end else if (req_size == SIZE_W) begin
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                            state          <= ST_STORE;
                        end else begin
                            mem_read <= 1'b1;
                            state    <= ST_RMW_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    mem_read   <= 1'b0;
                    resp_rdata <= ext_data;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_STORE: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RMW_RD: begin
                    mem_read       <= 1'b0;
                    mem_write      <= 1'b1;
                    mem_write_data <= merged;
                    state          <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_fault <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small behavioural 128-word data memory.
module tb_lsu;
    import lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:127];
    int tests_run = 0;
    int fails = 0;

    lsu dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_write(mem_write),
        .mem_read(mem_read), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    assign mem_data_out = mem[mem_address[6:0]];
    always @(posedge clock) if (mem_write) mem[mem_address[6:0]] <= mem_write_data;

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    // Watches the access until resp_valid; lat = 99 when it never comes.
    task automatic collect(output int lat, output int rd, output int wr, output logic both,
                           output logic [31:0] adr, output logic [31:0] wd,
                           output logic [31:0] rdata, output logic flt);
        lat = 99; rd = 0; wr = 0; both = 0; adr = '0; wd = '0; rdata = '0; flt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (mem_read) begin rd++; adr = mem_address; end
            if (mem_write) begin wr++; adr = mem_address; wd = mem_write_data; end
            if (mem_read && mem_write) both = 1'b1;
            if (resp_valid) begin lat = i; rdata = resp_rdata; flt = resp_fault; break; end
        end
    endtask

    task automatic transact(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] d,
                            output int lat, output int rd, output int wr, output logic both,
                            output logic [31:0] adr, output logic [31:0] wd,
                            output logic [31:0] rdata, output logic flt);
        issue(w, sz, u, a, d);
        collect(lat, rd, wr, both, adr, wd, rdata, flt);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        tests_run++; if ({resp_valid, resp_fault, mem_read, mem_write} !== 4'b0000) begin fails++; $display("FAIL rst_flags got %b want 0000", {resp_valid, resp_fault, mem_read, mem_write}); end
        tests_run++; if ({resp_rdata, mem_address, mem_write_data} !== 96'h0) begin fails++; $display("FAIL rst_data got %h want 0", {resp_rdata, mem_address, mem_write_data}); end
        reset = 1'b1;
        @(negedge clock);
        tests_run++; if ({req_ready, resp_valid} !== 2'b10) begin fails++; $display("FAIL rst_idle got %b want 10", {req_ready, resp_valid}); end
    endtask

    task automatic test_word();
        int lat, rd, wr; logic both, flt; logic [31:0] adr, wd, rdata;
        transact(1, SIZE_W, 0, 32'h10, 32'hDEADBEEF, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (lat !== 2) begin fails++; $display("FAIL sw_lat got %0d want 2", lat); end
        tests_run++; if ({rd, wr} !== {32'd0, 32'd1}) begin fails++; $display("FAIL sw_strobes got rd=%0d wr=%0d want rd=0 wr=1", rd, wr); end
        tests_run++; if (adr !== 32'd4) begin fails++; $display("FAIL sw_addr got %0d want 4", adr); end
        tests_run++; if (wd !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata got %h want deadbeef", wd); end
        tests_run++; if ({flt, rdata} !== 33'h0) begin fails++; $display("FAIL sw_resp got fault=%b rdata=%h want 0/0", flt, rdata); end
        transact(0, SIZE_W, 0, 32'h10, 32'h0, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (lat !== 2) begin fails++; $display("FAIL lw_lat got %0d want 2", lat); end
        tests_run++; if ({rd, wr} !== {32'd1, 32'd0}) begin fails++; $display("FAIL lw_strobes got rd=%0d wr=%0d want rd=1 wr=0", rd, wr); end
        tests_run++; if (adr !== 32'd4) begin fails++; $display("FAIL lw_addr got %0d want 4", adr); end
        tests_run++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata got %h want deadbeef", rdata); end
        transact(1, SIZE_W, 0, 32'h1FC, 32'hCAFEF00D, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if ({flt, adr} !== {1'b0, 32'd127}) begin fails++; $display("FAIL sw_top got fault=%b addr=%0d want 0/127", flt, adr); end
        transact(0, SIZE_W, 0, 32'h1FC, 32'h0, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL lw_top got %h want cafef00d", rdata); end
    endtask

    task automatic test_byte_rmw();
        int lat, rd, wr; logic both, flt; logic [31:0] adr, wd, rdata;
        transact(1, SIZE_W, 0, 32'h20, 32'h11223344, lat, rd, wr, both, adr, wd, rdata, flt);
        transact(1, SIZE_B, 0, 32'h21, 32'h123456AA, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (lat !== 3) begin fails++; $display("FAIL sb_lat got %0d want 3", lat); end
        tests_run++; if ({rd, wr} !== {32'd1, 32'd1}) begin fails++; $display("FAIL sb_strobes got rd=%0d wr=%0d want 1/1", rd, wr); end
        tests_run++; if (both !== 1'b0) begin fails++; $display("FAIL sb_overlap got %b want 0", both); end
        tests_run++; if (wd !== 32'h1122AA44) begin fails++; $display("FAIL sb_merge got %h want 1122aa44", wd); end
        tests_run++; if (mem[8] !== 32'h1122AA44) begin fails++; $display("FAIL sb_mem got %h want 1122aa44", mem[8]); end
        transact(0, SIZE_B, 0, 32'h21, 32'h0, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (rdata !== 32'hFFFFFFAA) begin fails++; $display("FAIL lb_signed got %h want ffffffaa", rdata); end
        transact(0, SIZE_B, 1, 32'h21, 32'h0, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (rdata !== 32'h000000AA) begin fails++; $display("FAIL lbu got %h want 000000aa", rdata); end
        transact(0, SIZE_B, 0, 32'h23, 32'h0, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (rdata !== 32'h00000011) begin fails++; $display("FAIL lb_lane3 got %h want 00000011", rdata); end
    endtask

    task automatic test_half();
        int lat, rd, wr; logic both, flt; logic [31:0] adr, wd, rdata;
        transact(1, SIZE_W, 0, 32'h30, 32'h80017FFF, lat, rd, wr, both, adr, wd, rdata, flt);
        transact(0, SIZE_H, 0, 32'h32, 32'h0, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (rdata !== 32'hFFFF8001) begin fails++; $display("FAIL lh_hi got %h want ffff8001", rdata); end
        transact(0, SIZE_H, 0, 32'h30, 32'h0, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (rdata !== 32'h00007FFF) begin fails++; $display("FAIL lh_lo got %h want 00007fff", rdata); end
        transact(0, SIZE_H, 1, 32'h32, 32'h0, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (rdata !== 32'h00008001) begin fails++; $display("FAIL lhu_hi got %h want 00008001", rdata); end
        transact(1, SIZE_H, 0, 32'h32, 32'h0000BEEF, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if ({lat, wd} !== {32'd3, 32'hBEEF7FFF}) begin fails++; $display("FAIL sh_hi got lat=%0d wdata=%h want 3/beef7fff", lat, wd); end
    endtask

    task automatic test_fault();
        int lat, rd, wr; logic both, flt; logic [31:0] adr, wd, rdata;
        logic [31:0] addrs [5] = '{32'h02, 32'h01, 32'h00, 32'h200, 32'h202};
        logic [1:0]  sizes [5] = '{SIZE_W, SIZE_H, 2'd3, SIZE_W, SIZE_B};
        logic        wrs   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            transact(wrs[k], sizes[k], 0, addrs[k], 32'hFFFFFFFF, lat, rd, wr, both, adr, wd, rdata, flt);
            tests_run++; if ({lat, rd, wr} !== {32'd1, 32'd0, 32'd0}) begin fails++; $display("FAIL flt%0d_timing got lat=%0d rd=%0d wr=%0d want 1/0/0", k, lat, rd, wr); end
            tests_run++; if ({flt, rdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL flt%0d_resp got fault=%b rdata=%h want 1/0", k, flt, rdata); end
        end
    endtask

    task automatic test_backpressure();
        int lat, rd, wr; logic both, flt; logic [31:0] adr, wd, rdata;
        resp_ready = 1'b0;
        issue(0, SIZE_W, 0, 32'h10, 32'h0);
        collect(lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if ({lat, rdata} !== {32'd2, 32'hDEADBEEF}) begin fails++; $display("FAIL bp_first got lat=%0d rdata=%h want 2/deadbeef", lat, rdata); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            tests_run++; if ({resp_valid, req_ready, resp_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin fails++; $display("FAIL bp_hold%0d got valid=%b ready=%b rdata=%h want 1/0/deadbeef", c, resp_valid, req_ready, resp_rdata); end
        end
        resp_ready = 1'b1;
        @(negedge clock);
        tests_run++; if ({req_ready, resp_valid} !== 2'b10) begin fails++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_reset_rmw();
        int lat, rd, wr; logic both, flt; logic [31:0] adr, wd, rdata;
        transact(1, SIZE_W, 0, 32'h40, 32'h01020304, lat, rd, wr, both, adr, wd, rdata, flt);
        issue(1, SIZE_B, 0, 32'h40, 32'h55);
        @(negedge clock);
        tests_run++; if ({mem_read, mem_write} !== 2'b10) begin fails++; $display("FAIL rmw_rd got rd=%b wr=%b want 1/0", mem_read, mem_write); end
        @(negedge clock);
        tests_run++; if ({mem_write, mem_address} !== {1'b1, 32'd16}) begin fails++; $display("FAIL rmw_wr got wr=%b addr=%0d want 1/16", mem_write, mem_address); end
        #2 reset = 1'b0;
        #1;
        tests_run++; if ({mem_write, mem_read, resp_valid, req_ready} !== 4'b0001) begin fails++; $display("FAIL abort_flags got %b want 0001", {mem_write, mem_read, resp_valid, req_ready}); end
        tests_run++; if ({mem_address, mem_write_data, resp_rdata} !== 96'h0) begin fails++; $display("FAIL abort_data got %h want 0", {mem_address, mem_write_data, resp_rdata}); end
        @(negedge clock);
        reset = 1'b1;
        tests_run++; if (mem[16] !== 32'h01020304) begin fails++; $display("FAIL abort_mem got %h want 01020304", mem[16]); end
        transact(1, SIZE_B, 0, 32'h40, 32'h55, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if ({lat, wd} !== {32'd3, 32'h01020355}) begin fails++; $display("FAIL post_rst_sb got lat=%0d wdata=%h want 3/01020355", lat, wd); end
        transact(0, SIZE_W, 0, 32'h40, 32'h0, lat, rd, wr, both, adr, wd, rdata, flt);
        tests_run++; if (rdata !== 32'h01020355) begin fails++; $display("FAIL post_rst_lw got %h want 01020355", rdata); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_rmw();
        test_half();
        test_fault();
        test_backpressure();
        test_reset_rmw();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
